hazard_arbiter_n: RTL and testbench
===================================

// Module: hazard_arbiter_n
// PURPOSE
//  Parametrised successor to the 5-stage hazard controller: resolves stall, flush and PC-redirect
//  requests for an N-stage in-order pipeline. Replaces the fixed IF/DEC/EX/MEM logic with a
//  generic backward-propagating stall chain and prioritised multi-source redirect.
//  Adds a pending-redirect register for redirects raised under downstream stall.
//  Adds per-stage saturating stall counters and a stall watchdog.
// PARAMETERS
//  NUM_STAGES  5   pipeline stages; stage 0 = fetch, stage NUM_STAGES-1 = last stalling stage
//  NUM_REDIR   2   redirect sources; source r sits in stage r+1 (r=0 decode, r=1 execute)
//  ADDR_W      32  PC width
//  CNT_W       16  width of each stall counter
//  WDOG_CYC    1024  consecutive stage-0 hold cycles that raise deadlock_o
// PORTS
//  clk             in   1                 clock
//  rst             in   1                 synchronous, active-high reset
//  stall_req       in   NUM_STAGES        stage i cannot complete this cycle (cache miss, lw hazard, ...)
//  redir_valid     in   NUM_REDIR         source r requests a PC redirect (may be a 1-cycle pulse)
//  redir_pc        in   NUM_REDIR*ADDR_W  target of source r; slice r = [r*ADDR_W +: ADDR_W]
//  stall_o         out  NUM_STAGES        input register of stage i holds its value
//  flush_o         out  NUM_STAGES        register after stage i loads a bubble (bit N-1 feeds writeback)
//  load_pc_we      out  1                 write new_pc into the fetch PC this cycle
//  load_pc_new_pc  out  ADDR_W            redirect target
//  cnt_clear       in   1                 synchronous clear of all counters and deadlock_o
//  stall_cnt       out  NUM_STAGES*CNT_W  saturating cycles stage i had stall_o=1
//  redir_cnt       out  CNT_W             saturating count of applied redirects
//  deadlock_o      out  1                 sticky: stage-0 hold lasted WDOG_CYC cycles
// BEHAVIOUR
//  Reset: stall_o=0, flush_o=0, load_pc_we=0, load_pc_new_pc=0, pending cleared,
//   counters 0, watchdog count 0, deadlock_o=0. Reset mid-redirect discards pending.
//  Stall chain (comb): hold[N]=0; hold[i]=stall_req[i]|hold[i+1].
//   stall_o[i]=hold[i]. flush_o[i]=stall_req[i] & ~hold[i+1] (bubble behind a locally stalled stage).
//  Redirect source r, stage s=r+1, is eligible when ~hold[s].
//  Eligible live redirect wins over pending. Among live ones, highest r (oldest instruction) wins.
//  Apply (0-cycle latency, same cycle):
//   - load_pc_we=1 and load_pc_new_pc=target.
//   - flush_o[j]=1 for all j<s.
//   - stall_o[j]=0 for all j<s. This overrides local stall_req, e.g. an I-cache miss.
//   - stall_o[j] for j>=s is unchanged.
//  Pending FSM, states IDLE/PEND:
//   IDLE: any redir_valid[r] with hold[r+1]=1 and nothing applied -> latch {pc,r}, go to PEND.
//   PEND: applied when ~hold[s_pend] and no live eligible redirect with r>=r_pend -> IDLE.
//    A live redirect with r>r_pend, whether applied or latched, replaces pending.
//    A live redirect with r<r_pend is ignored; it lies on the wrong path.
//    A live redirect with r==r_pend is applied live, or overwrites pending -> IDLE.
//   A redirect is never dropped and never applied twice.
//  Counters: per cycle stall_cnt[i]+=stall_o[i]; redir_cnt+=load_pc_we.
//   All counters saturate at 2^CNT_W-1 and do not wrap.
//   cnt_clear wins over increment in the same cycle, so the value is 0 next cycle.
//  Watchdog: wd counts consecutive cycles with hold[0]=1 and resets to 0 on any cycle with hold[0]=0.
//   deadlock_o sets the cycle after wd reaches WDOG_CYC and stays set until rst or cnt_clear.
//   deadlock_o is diagnostic only and affects no control output.
//  With NUM_STAGES=5 and NUM_REDIR=2, outputs match the legacy controller, except redirect under
//   downstream stall, which is now deferred instead of applied.
// TESTING
//  1 stall_req=5'b00100 one cycle -> stall_o=00111, flush_o=00100; next cycle all 0.
//  2 stall_req[0]=1 with redir_valid[1]=1, pc=0x400 -> load_pc_we=1, new_pc=0x400,
//    stall_o[0..1]=0, flush_o[0..1]=1 in that cycle.
//  3 redir_valid[1] pulse pc=0x800 while stall_req[3]=1 for 3 cycles -> load_pc_we=0 for those
//    3 cycles, then 1 with 0x800 on the cycle stall_req[3] drops; redir_cnt=1.
//  4 Pending r=0 pc=0x100, then live r=1 pc=0x200 while held -> only 0x200 applied, exactly once.
//    Then a live r=0 under pending r=1 -> ignored.
//  5 CNT_W=4, stall_req[4]=1 for 20 cycles -> stall_cnt[4]=15 (saturated).
//    cnt_clear plus stall same cycle -> 0.
//  6 WDOG_CYC=8, stall_req[2] held 8 cycles -> deadlock_o=1 on cycle 9, stays 1 after stall drops.
//    rst mid-PEND -> no later load_pc_we.

Source files
------------

// File: rtl/hazard_arbiter_n.sv
// Stall/flush/redirect arbiter for an N-stage in-order pipeline.
// Also keeps a pending redirect, saturating stall/redirect counters and a stage-0 stall watchdog.
module hazard_arbiter_n #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_REDIR  = 2,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int WDOG_CYC   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_STAGES-1:0]         stall_req,
  input  logic [NUM_REDIR-1:0]          redir_valid,
  input  logic [NUM_REDIR*ADDR_W-1:0]   redir_pc,
  output logic [NUM_STAGES-1:0]         stall_o,
  output logic [NUM_STAGES-1:0]         flush_o,
  output logic                          load_pc_we,
  output logic [ADDR_W-1:0]             load_pc_new_pc,
  input  logic                          cnt_clear,
  output logic [NUM_STAGES*CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]              redir_cnt,
  output logic                          deadlock_o
);

  localparam int RW   = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
  localparam int WD_W = $clog2(WDOG_CYC + 1);

  typedef enum logic {IDLE, PEND} pend_state_e;

  pend_state_e       state_q, state_d;
  logic [RW-1:0]     pend_r_q, pend_r_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q [NUM_STAGES];
  logic [CNT_W-1:0]  stall_cnt_d [NUM_STAGES];
  logic [CNT_W-1:0]  redir_cnt_q, redir_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              deadlock_q, deadlock_d;

  logic [NUM_STAGES:0] hold;
  logic                live_any, latch_any, use_live, use_pend, apply;
  logic [RW-1:0]       live_r, latch_r, apply_r;
  logic [ADDR_W-1:0]   live_pc, latch_pc, apply_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    hold = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) hold[i] = stall_req[i] | hold[i+1];
  end

  // Ascending scan: the last hit is the highest (oldest) source.
  always_comb begin
    live_any  = 1'b0;
    live_r    = '0;
    live_pc   = '0;
    latch_any = 1'b0;
    latch_r   = '0;
    latch_pc  = '0;
    for (int r = 0; r < NUM_REDIR; r++) begin
      if (redir_valid[r] && !hold[r+1]) begin
        live_any = 1'b1;
        live_r   = RW'(r);
        live_pc  = redir_pc[r*ADDR_W +: ADDR_W];
      end
      if (redir_valid[r] && (state_q == IDLE || RW'(r) >= pend_r_q)) begin
        latch_any = 1'b1;
        latch_r   = RW'(r);
        latch_pc  = redir_pc[r*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    use_live = live_any && (state_q == IDLE || live_r >= pend_r_q);
    use_pend = !use_live && (state_q == PEND) && !hold[int'(pend_r_q) + 1];
    apply    = (use_live || use_pend) && !rst;
    apply_r  = use_live ? live_r : pend_r_q;
    apply_pc = use_live ? live_pc : pend_pc_q;

    state_d   = state_q;
    pend_r_d  = pend_r_q;
    pend_pc_d = pend_pc_q;
    // Anything valid that was neither applied nor on the wrong path is still held: keep it.
    if (use_live || use_pend) begin
      state_d = IDLE;
    end else if (latch_any) begin
      state_d   = PEND;
      pend_r_d  = latch_r;
      pend_pc_d = latch_pc;
    end
  end

  always_comb begin
    stall_o        = '0;
    flush_o        = '0;
    load_pc_we     = apply;
    load_pc_new_pc = apply ? apply_pc : '0;
    if (!rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stall_o[i] = hold[i] & ~(apply && i <= int'(apply_r));
        flush_o[i] = (stall_req[i] & ~hold[i+1]) | (apply && i <= int'(apply_r));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      stall_cnt_d[i] = cnt_clear ? '0 : sat_inc(stall_cnt_q[i], stall_o[i]);
      stall_cnt[i*CNT_W +: CNT_W] = stall_cnt_q[i];
    end
    redir_cnt_d = cnt_clear ? '0 : sat_inc(redir_cnt_q, load_pc_we);
    wd_d        = '0;
    if (hold[0]) wd_d = (wd_q == WD_W'(WDOG_CYC)) ? wd_q : wd_q + 1'b1;
    deadlock_d  = deadlock_q | (wd_d == WD_W'(WDOG_CYC));
    if (cnt_clear) begin
      wd_d       = '0;
      deadlock_d = 1'b0;
    end
    redir_cnt  = redir_cnt_q;
    deadlock_o = deadlock_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_r_q    <= '0;
      redir_cnt_q <= '0;
      wd_q        <= '0;
      deadlock_q  <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) stall_cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pend_r_q    <= pend_r_d;
      redir_cnt_q <= redir_cnt_d;
      wd_q        <= wd_d;
      deadlock_q  <= deadlock_d;
      for (int i = 0; i < NUM_STAGES; i++) stall_cnt_q[i] <= stall_cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
  end

endmodule

// File: tb/tb_hazard_arbiter_n.sv
// Directed bench for hazard_arbiter_n (5 stages, 2 redirect sources, CNT_W=4, WDOG_CYC=8).
module tb_hazard_arbiter_n;

  localparam int NS = 5;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     stall_req;
  logic [NR-1:0]     redir_valid;
  logic [NR*AW-1:0]  redir_pc;
  logic [NS-1:0]     stall_o;
  logic [NS-1:0]     flush_o;
  logic              load_pc_we;
  logic [AW-1:0]     load_pc_new_pc;
  logic              cnt_clear;
  logic [NS*CW-1:0]  stall_cnt;
  logic [CW-1:0]     redir_cnt;
  logic              deadlock_o;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_arbiter_n #(
    .NUM_STAGES(NS), .NUM_REDIR(NR), .ADDR_W(AW), .CNT_W(CW), .WDOG_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .stall_o(stall_o), .flush_o(flush_o), .load_pc_we(load_pc_we),
    .load_pc_new_pc(load_pc_new_pc), .cnt_clear(cnt_clear), .stall_cnt(stall_cnt),
    .redir_cnt(redir_cnt), .deadlock_o(deadlock_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [NS-1:0] sr, input logic [NR-1:0] rv,
                       input logic [AW-1:0] pc0, input logic [AW-1:0] pc1);
    stall_req   = sr;
    redir_valid = rv;
    redir_pc    = {pc1, pc0};
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] scnt(input int i);
    return stall_cnt[i*CW +: CW];
  endfunction

  initial begin
    rst = 1'b1;
    cnt_clear = 1'b0;
    drive('0, '0, '0, '0);
    adv();
    adv();
    rst = 1'b0;

    @(negedge clk);
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_flush", 32'(flush_o), 32'h0);
    check("rst_we", 32'(load_pc_we), 32'h0);
    check("rst_pc", load_pc_new_pc, 32'h0);
    check("rst_rcnt", 32'(redir_cnt), 32'h0);
    check("rst_dl", 32'(deadlock_o), 32'h0);
    adv();

    // 1: single local stall in stage 2
    drive(5'b00100, '0, '0, '0);
    @(negedge clk);
    check("t1_stall", 32'(stall_o), 32'h07);
    check("t1_flush", 32'(flush_o), 32'h04);
    adv();
    drive('0, '0, '0, '0);
    @(negedge clk);
    check("t1_stall_off", 32'(stall_o), 32'h0);
    check("t1_flush_off", 32'(flush_o), 32'h0);
    adv();

    // 2: execute redirect overrides fetch stall
    drive(5'b00001, 2'b10, 32'h0, 32'h400);
    @(negedge clk);
    check("t2_we", 32'(load_pc_we), 32'h1);
    check("t2_pc", load_pc_new_pc, 32'h400);
    check("t2_stall", 32'(stall_o), 32'h0);
    check("t2_flush", 32'(flush_o), 32'h03);
    adv();

    drive('0, '0, '0, '0);
    cnt_clear = 1'b1;
    adv();
    cnt_clear = 1'b0;

    // 3: redirect pulse under downstream stall is deferred
    drive(5'b01000, 2'b10, 32'h0, 32'h800);
    @(negedge clk);
    check("t3_we_a", 32'(load_pc_we), 32'h0);
    check("t3_stall_a", 32'(stall_o), 32'h0f);
    check("t3_flush_a", 32'(flush_o), 32'h08);
    adv();
    for (int k = 0; k < 2; k++) begin
      drive(5'b01000, '0, '0, '0);
      @(negedge clk);
      check("t3_we_hold", 32'(load_pc_we), 32'h0);
      adv();
    end
    drive('0, '0, '0, '0);
    @(negedge clk);
    check("t3_we_rel", 32'(load_pc_we), 32'h1);
    check("t3_pc_rel", load_pc_new_pc, 32'h800);
    check("t3_flush_rel", 32'(flush_o), 32'h03);
    check("t3_scnt3", 32'(scnt(3)), 32'h3);
    check("t3_scnt4", 32'(scnt(4)), 32'h0);
    adv();
    @(negedge clk);
    check("t3_we_once", 32'(load_pc_we), 32'h0);
    check("t3_rcnt", 32'(redir_cnt), 32'h1);
    adv();

    // 4: older live redirect replaces younger pending
    drive(5'b00100, 2'b01, 32'h100, 32'h0);
    @(negedge clk);
    check("t4_we_e", 32'(load_pc_we), 32'h0);
    adv();
    drive(5'b00100, 2'b10, 32'h0, 32'h200);
    @(negedge clk);
    check("t4_we_f", 32'(load_pc_we), 32'h0);
    adv();
    drive('0, '0, '0, '0);
    @(negedge clk);
    check("t4_we_g", 32'(load_pc_we), 32'h1);
    check("t4_pc_g", load_pc_new_pc, 32'h200);
    adv();
    @(negedge clk);
    check("t4_we_h", 32'(load_pc_we), 32'h0);
    check("t4_rcnt", 32'(redir_cnt), 32'h2);
    adv();

    // 4b: younger redirects under pending r=1 are wrong-path
    drive(5'b00100, 2'b10, 32'h0, 32'h300);
    adv();
    drive(5'b00100, 2'b01, 32'h500, 32'h0);
    @(negedge clk);
    check("t4b_we_held", 32'(load_pc_we), 32'h0);
    adv();
    drive('0, 2'b01, 32'h600, 32'h0);
    @(negedge clk);
    check("t4b_we", 32'(load_pc_we), 32'h1);
    check("t4b_pc", load_pc_new_pc, 32'h300);
    check("t4b_flush", 32'(flush_o), 32'h03);
    adv();
    drive('0, '0, '0, '0);
    @(negedge clk);
    check("t4b_we_after", 32'(load_pc_we), 32'h0);
    adv();

    // priority between two live eligible sources
    drive('0, 2'b11, 32'h10, 32'h20);
    @(negedge clk);
    check("prio_pc", load_pc_new_pc, 32'h20);
    check("prio_flush", 32'(flush_o), 32'h03);
    adv();

    drive('0, '0, '0, '0);
    cnt_clear = 1'b1;
    adv();
    cnt_clear = 1'b0;

    // 5: counter saturation, then clear beats increment
    for (int k = 0; k < 20; k++) begin
      drive(5'b10000, '0, '0, '0);
      adv();
    end
    cnt_clear = 1'b1;
    @(negedge clk);
    check("t5_sat", 32'(scnt(4)), 32'hf);
    check("t5_scnt0_sat", 32'(scnt(0)), 32'hf);
    check("t5_dl_set", 32'(deadlock_o), 32'h1);
    adv();
    cnt_clear = 1'b0;
    drive('0, '0, '0, '0);
    @(negedge clk);
    check("t5_clr", 32'(scnt(4)), 32'h0);
    check("t5_dl_clr", 32'(deadlock_o), 32'h0);
    adv();

    // 6: watchdog trips after 8 held cycles
    for (int k = 1; k <= 8; k++) begin
      drive(5'b00100, '0, '0, '0);
      @(negedge clk);
      if (k == 1 || k == 8) check("t6_dl_pre", 32'(deadlock_o), 32'h0);
      adv();
    end
    drive('0, '0, '0, '0);
    @(negedge clk);
    check("t6_dl_c9", 32'(deadlock_o), 32'h1);
    adv();
    @(negedge clk);
    check("t6_dl_sticky", 32'(deadlock_o), 32'h1);
    adv();

    // reset while a redirect is pending discards it
    drive(5'b01000, 2'b10, 32'h0, 32'h900);
    @(negedge clk);
    check("t6_we_latch", 32'(load_pc_we), 32'h0);
    adv();
    drive(5'b01000, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_stall_in_rst", 32'(stall_o), 32'h0);
    adv();
    rst = 1'b0;
    drive('0, '0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_we_post_rst", 32'(load_pc_we), 32'h0);
      adv();
    end
    @(negedge clk);
    check("t6_dl_post_rst", 32'(deadlock_o), 32'h0);
    check("t6_rcnt_post_rst", 32'(redir_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
